// File: rtl/mmu_pmp_check.sv
// mmu_pmp_check: PMP checker behind the L1 TLB.
// Two request channels (pmp0 = direct translations, pmp1 = TLB hits) are
// arbitrated into S1, checked against PMP_ENTRIES cfg/addr pairs, and the
// S2 result register drives either the grant channel or the fault channel.
// Optional feature: define MMU_PMP_TOR_EN to build TOR (A=01) matching;
// without it A=01 never matches and no range comparators exist.

// Match logic for a single PMP entry.
module mmu_pmp_entry (
  input  logic [31:0] pa,
  input  logic [1:0]  a,
  input  logic [31:0] addr,
`ifdef MMU_PMP_TOR_EN
  input  logic [31:0] addr_lo,
`endif
  output logic        hit,
  output logic        active
);
  logic [31:0] mask;
  logic        tor_hit;

  // Decode the address-match mode and compare against pa.
  always_comb begin
    // Trailing ones of addr plus the following zero: bits [k:0] are don't-care.
    mask = addr ^ (addr + 32'd1);
`ifdef MMU_PMP_TOR_EN
    tor_hit = (pa >= addr_lo) && (pa < addr);
`else
    tor_hit = 1'b0;
`endif
    unique case (a)
      2'b01:   hit = tor_hit;
      2'b10:   hit = (pa == addr);
      2'b11:   hit = ((pa ^ addr) & ~mask) == 32'd0;
      default: hit = 1'b0;
    endcase
    // The raw A field decides whether the entry counts as configured, even
    // when A=01 cannot match in a build without TOR.
    active = (a != 2'b00);
  end
endmodule

module mmu_pmp_check #(
  parameter int PMP_ENTRIES = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      i_pmp0_drive_1,
  output logic                      o_pmp0_free_1,
  input  logic [47:0]               i_pmp0_data_48,
  input  logic                      i_pmp1_drive_1,
  output logic                      o_pmp1_free_1,
  input  logic [47:0]               i_pmp1_data_48,
  input  logic [8*PMP_ENTRIES-1:0]  i_pmpcfg_8N,
  input  logic [32*PMP_ENTRIES-1:0] i_pmpaddr_32N,
  output logic                      o_resp_drive_1,
  input  logic                      i_resp_free_1,
  output logic [45:0]               o_resp_data_46,
  output logic                      o_exp_drive_1,
  input  logic                      i_exp_free_1,
  output logic [10:0]               o_exp_data_11
);
  // Packet layout: [47:44] tlb idx, [43:38] inst idx, [37:4] pAddr,
  // [3:2] cpuMode, [1:0] instType.
  logic        run;
  logic        ptr;
  logic        s1_vld;
  logic [47:0] s1_pkt;

  logic        s2_vld, s2_fire, s2_load_ok;
  logic        s1_adv, s1_loadable, s1_load, sel1, both;

  logic [31:0] pa;
  logic [1:0]  mode, typ;
  logic [PMP_ENTRIES-1:0] hit, active;
  logic [7:0]  cfg [PMP_ENTRIES];
  logic        any_hit, any_active, perm, fault;
  logic [7:0]  hit_cfg;
  logic [4:0]  code;
  logic        cfg_unused;

  assign pa   = s1_pkt[37:6];
  assign mode = s1_pkt[3:2];
  assign typ  = s1_pkt[1:0];

  for (genvar g = 0; g < PMP_ENTRIES; g++) begin : g_ent
    assign cfg[g] = i_pmpcfg_8N[8*g +: 8];
`ifdef MMU_PMP_TOR_EN
    logic [31:0] lo;
    if (g == 0) begin : g_lo0
      assign lo = 32'd0;
    end else begin : g_lon
      assign lo = i_pmpaddr_32N[32*(g-1) +: 32];
    end
`endif
    mmu_pmp_entry u_ent (
      .pa      (pa),
      .a       (cfg[g][4:3]),
      .addr    (i_pmpaddr_32N[32*g +: 32]),
`ifdef MMU_PMP_TOR_EN
      .addr_lo (lo),
`endif
      .hit     (hit[g]),
      .active  (active[g])
    );
  end

  // Handshake and arbitration: frees depend on pipeline state and the
  // other channel's drive only.
  always_comb begin
    s2_vld      = o_resp_drive_1 | o_exp_drive_1;
    s2_fire     = (o_resp_drive_1 & i_resp_free_1) | (o_exp_drive_1 & i_exp_free_1);
    s2_load_ok  = ~s2_vld | s2_fire;
    s1_adv      = s1_vld & s2_load_ok;
    s1_loadable = run & (~s1_vld | s2_load_ok);
    both        = i_pmp0_drive_1 & i_pmp1_drive_1;
    sel1        = i_pmp1_drive_1 & (~i_pmp0_drive_1 | ptr);
    s1_load     = s1_loadable & (i_pmp0_drive_1 | i_pmp1_drive_1);
    o_pmp0_free_1 = s1_loadable & ~(i_pmp1_drive_1 & ptr);
    o_pmp1_free_1 = s1_loadable & ~(i_pmp0_drive_1 & ~ptr);
  end

  // Lowest-index match, permission lookup and grant/fault decision on S1.
  always_comb begin
    any_hit = 1'b0;
    hit_cfg = 8'd0;
    for (int i = PMP_ENTRIES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        any_hit = 1'b1;
        hit_cfg = cfg[i];
      end
    end
    any_active = |active;
    unique case (typ)
      2'b00:   begin perm = hit_cfg[2]; code = 5'd1; end
      2'b11:   begin perm = hit_cfg[1]; code = 5'd7; end
      default: begin perm = hit_cfg[0]; code = 5'd5; end
    endcase
    if (mode == 2'b11) fault = any_hit & hit_cfg[7] & ~perm;
    else               fault = any_hit ? ~perm : any_active;
    cfg_unused = ^hit_cfg[6:3];
  end

  // Leaves the idle-after-reset state one cycle after rstn releases.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) run <= 1'b0;
    else       run <= 1'b1;
  end

  // S1 request register and round-robin pointer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_vld <= 1'b0;
      s1_pkt <= 48'd0;
      ptr    <= 1'b0;
    end else if (s1_load) begin
      s1_vld <= 1'b1;
      s1_pkt <= sel1 ? i_pmp1_data_48 : i_pmp0_data_48;
      if (both) ptr <= ~ptr;
    end else if (s1_adv) begin
      s1_vld <= 1'b0;
    end
  end

  // S2 result register; config is captured here via the S1 check result.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_resp_drive_1 <= 1'b0;
      o_resp_data_46 <= 46'd0;
      o_exp_drive_1  <= 1'b0;
      o_exp_data_11  <= 11'd0;
    end else if (s2_load_ok) begin
      o_resp_drive_1 <= s1_vld & ~fault;
      o_exp_drive_1  <= s1_vld & fault;
      o_resp_data_46 <= (s1_vld & ~fault) ? {s1_pkt[47:38], s1_pkt[37:4], s1_pkt[1:0]} : 46'd0;
      o_exp_data_11  <= (s1_vld & fault) ? {s1_pkt[43:38], code} : 11'd0;
    end
  end
endmodule

// File: tb/tb_mmu_pmp_check.sv
// Directed bench for mmu_pmp_check with hand-computed expectations.
module tb_mmu_pmp_check;
  localparam int N = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          drive0, drive1, free0, free1;
  logic [47:0]   data0, data1;
  logic [8*N-1:0]  cfg;
  logic [32*N-1:0] addr;
  logic          resp_drive, resp_free, exp_drive, exp_free;
  logic [45:0]   resp_data;
  logic [10:0]   exp_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mmu_pmp_check #(.PMP_ENTRIES(N)) dut (
    .clk(clk), .rstn(rstn),
    .i_pmp0_drive_1(drive0), .o_pmp0_free_1(free0), .i_pmp0_data_48(data0),
    .i_pmp1_drive_1(drive1), .o_pmp1_free_1(free1), .i_pmp1_data_48(data1),
    .i_pmpcfg_8N(cfg), .i_pmpaddr_32N(addr),
    .o_resp_drive_1(resp_drive), .i_resp_free_1(resp_free), .o_resp_data_46(resp_data),
    .o_exp_drive_1(exp_drive), .i_exp_free_1(exp_free), .o_exp_data_11(exp_data)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [47:0] pk(input logic [3:0] t, input logic [5:0] i,
                                     input logic [33:0] p, input logic [1:0] m,
                                     input logic [1:0] y);
    return {t, i, p, m, y};
  endfunction

  function automatic logic [45:0] rsp(input logic [47:0] p);
    return {p[47:38], p[37:4], p[1:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_entry(input int i, input logic [7:0] c, input logic [31:0] a);
    cfg[8*i +: 8]   = c;
    addr[32*i +: 32] = a;
  endtask

  // Present a packet, wait (bounded) for free, transfer, drop drive.
  task automatic send(input bit ch, input logic [47:0] p);
    int n;
    n = 0;
    if (ch) begin drive1 = 1'b1; data1 = p; end
    else    begin drive0 = 1'b1; data0 = p; end
    #1;
    while (!(ch ? free1 : free0) && n < 20) begin
      tick();
      n++;
    end
    chk("send_accept", {63'd0, (n < 20)}, 64'd1);
    tick();
    if (ch) drive1 = 1'b0;
    else    drive0 = 1'b0;
  endtask

  task automatic expect_resp(input string tag, input logic [47:0] p);
    tick();
    chk({tag, "_rdrv"}, {63'd0, resp_drive}, 64'd1);
    chk({tag, "_rdat"}, {18'd0, resp_data}, {18'd0, rsp(p)});
    chk({tag, "_edrv"}, {63'd0, exp_drive}, 64'd0);
    chk({tag, "_edat"}, {53'd0, exp_data}, 64'd0);
  endtask

  task automatic expect_exp(input string tag, input logic [5:0] inst, input logic [4:0] code);
    tick();
    chk({tag, "_edrv"}, {63'd0, exp_drive}, 64'd1);
    chk({tag, "_edat"}, {53'd0, exp_data}, {53'd0, inst, code});
    chk({tag, "_rdrv"}, {63'd0, resp_drive}, 64'd0);
    chk({tag, "_rdat"}, {18'd0, resp_data}, 64'd0);
  endtask

  logic [47:0] pa0, pa1, pb0, pb1, p;

  initial begin
    rstn = 1'b0; drive0 = 1'b0; drive1 = 1'b0; data0 = '0; data1 = '0;
    cfg = '0; addr = '0; resp_free = 1'b1; exp_free = 1'b1;
    #3;
    chk("rst_rdrv", {63'd0, resp_drive}, 64'd0);
    chk("rst_edrv", {63'd0, exp_drive}, 64'd0);
    chk("rst_free0", {63'd0, free0}, 64'd0);
    chk("rst_free1", {63'd0, free1}, 64'd0);
    chk("rst_rdat", {18'd0, resp_data}, 64'd0);
    tick(); tick();
    rstn = 1'b1;
    tick();
    chk("post_rst_free0", {63'd0, free0}, 64'd1);
    chk("post_rst_free1", {63'd0, free1}, 64'd1);

    // NAPOT 0x3FF covers pa 0..0x7FF (pAddr 0..0x1FFF), R+W.
    set_entry(0, 8'h1B, 32'h0000_03FF);
    p = pk(4'd3, 6'd5, 34'h0_0000_0800, 2'b01, 2'b10);
    send(1'b1, p);
    expect_resp("s_load", p);

    p = pk(4'd1, 6'd9, 34'h0_0000_0800, 2'b01, 2'b00);
    send(1'b0, p);
    expect_exp("s_fetch", 6'd9, 5'd1);

    // Just past the NAPOT region: no match, entry active.
    p = pk(4'd2, 6'd4, 34'h0_0000_2000, 2'b01, 2'b01);
    send(1'b0, p);
    expect_exp("napot_edge", 6'd4, 5'd5);

    // Entry 1 grants X over the same range, but entry 0 has priority.
    set_entry(1, 8'h1C, 32'h0000_03FF);
    p = pk(4'd2, 6'd11, 34'h0_0000_0400, 2'b00, 2'b00);
    send(1'b1, p);
    expect_exp("prio_low", 6'd11, 5'd1);
    set_entry(1, 8'h00, 32'h0);

    // NA4 exact word match vs next word.
    set_entry(0, 8'h13, 32'h0000_0200);
    p = pk(4'd6, 6'd12, 34'h0_0000_0800, 2'b00, 2'b10);
    send(1'b0, p);
    expect_resp("na4_hit", p);
    p = pk(4'd6, 6'd13, 34'h0_0000_0804, 2'b00, 2'b10);
    send(1'b0, p);
    expect_exp("na4_miss", 6'd13, 5'd5);

    // All OFF: U-mode store granted.
    set_entry(0, 8'h00, 32'h0);
    p = pk(4'd7, 6'd20, 34'h0_0000_1000, 2'b00, 2'b11);
    send(1'b1, p);
    expect_resp("all_off", p);

    // TOR entry (0..0x100), pa 0x400 outside, entry active -> store fault.
    set_entry(0, 8'h08, 32'h0000_0100);
    p = pk(4'd7, 6'd21, 34'h0_0000_1000, 2'b00, 2'b11);
    send(1'b1, p);
    expect_exp("tor_nomatch", 6'd21, 5'd7);

    // M-mode with locked R-only region: store faults; unlocked: granted.
    set_entry(0, 8'h99, 32'h0000_03FF);
    p = pk(4'd8, 6'd30, 34'h0_0000_0800, 2'b11, 2'b11);
    send(1'b0, p);
    expect_exp("m_locked", 6'd30, 5'd7);
    set_entry(0, 8'h19, 32'h0000_03FF);
    p = pk(4'd8, 6'd31, 34'h0_0000_0800, 2'b11, 2'b11);
    send(1'b0, p);
    expect_resp("m_unlocked", p);
    tick();

    // Contention: alternating grants starting with pmp0.
    set_entry(0, 8'h00, 32'h0);
    pa0 = pk(4'd1, 6'd1, 34'h0_0000_0010, 2'b11, 2'b10);
    pb0 = pk(4'd2, 6'd2, 34'h0_0000_0020, 2'b11, 2'b10);
    pa1 = pk(4'd3, 6'd3, 34'h0_0000_0030, 2'b11, 2'b10);
    pb1 = pk(4'd4, 6'd4, 34'h0_0000_0040, 2'b11, 2'b10);
    drive0 = 1'b1; data0 = pa0; drive1 = 1'b1; data1 = pb0;
    #1;
    chk("arb0_free0", {63'd0, free0}, 64'd1);
    chk("arb0_free1", {63'd0, free1}, 64'd0);
    tick();
    data0 = pa1;
    #1;
    chk("arb1_free0", {63'd0, free0}, 64'd0);
    chk("arb1_free1", {63'd0, free1}, 64'd1);
    tick();
    chk("arb_out0", {18'd0, resp_data}, {18'd0, rsp(pa0)});
    data1 = pb1;
    #1;
    chk("arb2_free0", {63'd0, free0}, 64'd1);
    chk("arb2_free1", {63'd0, free1}, 64'd0);
    tick();
    chk("arb_out1", {18'd0, resp_data}, {18'd0, rsp(pb0)});
    drive0 = 1'b0;
    #1;
    chk("arb3_free1", {63'd0, free1}, 64'd1);
    tick();
    chk("arb_out2", {18'd0, resp_data}, {18'd0, rsp(pa1)});
    drive1 = 1'b0;
    tick();
    chk("arb_out3", {18'd0, resp_data}, {18'd0, rsp(pb1)});
    tick();
    chk("arb_idle", {63'd0, resp_drive}, 64'd0);

    // Stall: two packets accepted, then frees drop; reset mid-stall.
    resp_free = 1'b0;
    pa0 = pk(4'd9, 6'd40, 34'h0_0000_0100, 2'b11, 2'b11);
    pa1 = pk(4'd9, 6'd41, 34'h0_0000_0200, 2'b11, 2'b11);
    send(1'b0, pa0);
    drive0 = 1'b1; data0 = pa1;
    #1;
    chk("stall_acc2", {63'd0, free0}, 64'd1);
    tick();
    drive0 = 1'b0;
    #1;
    chk("stall_free0", {63'd0, free0}, 64'd0);
    chk("stall_free1", {63'd0, free1}, 64'd0);
    chk("stall_rdrv", {63'd0, resp_drive}, 64'd1);
    chk("stall_rdat", {18'd0, resp_data}, {18'd0, rsp(pa0)});
    // A config change must not disturb the held result.
    set_entry(0, 8'h98, 32'hFFFF_FFFF);
    tick();
    chk("held_rdat", {18'd0, resp_data}, {18'd0, rsp(pa0)});
    chk("held_edrv", {63'd0, exp_drive}, 64'd0);
    rstn = 1'b0;
    #1;
    chk("midrst_rdrv", {63'd0, resp_drive}, 64'd0);
    chk("midrst_edrv", {63'd0, exp_drive}, 64'd0);
    chk("midrst_rdat", {18'd0, resp_data}, 64'd0);
    chk("midrst_free0", {63'd0, free0}, 64'd0);
    tick();
    rstn = 1'b1;
    set_entry(0, 8'h00, 32'h0);
    tick();
    chk("rel_free0", {63'd0, free0}, 64'd1);
    chk("rel_free1", {63'd0, free1}, 64'd1);
    resp_free = 1'b1;
    tick(); tick();
    chk("rel_rdrv", {63'd0, resp_drive}, 64'd0);
    chk("rel_edrv", {63'd0, exp_drive}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
